// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file: 2 comb reads, 2 sync writes, load busy scoreboard
module regfile_mp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    localparam int NUM_REGS = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    output logic                rd_busy1,
    output logic                rd_busy2,
    input  logic                wa_en,
    input  logic [ADDR_W-1:0]   wa_addr,
    input  logic [DATA_W-1:0]   wa_data,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                mark_en,
    input  logic [ADDR_W-1:0]   mark_addr,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if ((ZERO_REG != 0) && (i == 0)) begin
                    regs[i] <= '0;
                    busy[i] <= 1'b0;
                end else begin
                    // ALU result is the younger instruction, so port A wins a collision
                    if (wa_en && (wa_addr == ADDR_W'(i))) begin
                        regs[i] <= wa_data;
                    end else if (wb_en && (wb_addr == ADDR_W'(i))) begin
                        regs[i] <= wb_data;
                    end
                    // a new load issued as the old one returns keeps the register busy
                    if (mark_en && (mark_addr == ADDR_W'(i))) begin
                        busy[i] <= 1'b1;
                    end else if (wb_en && (wb_addr == ADDR_W'(i))) begin
                        busy[i] <= 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = regs[a];
        if ((BYPASS != 0) && wa_en && (wa_addr == a)) begin
            v = wa_data;
        end else if ((BYPASS != 0) && wb_en && (wb_addr == a)) begin
            v = wb_data;
        end
        if ((ZERO_REG != 0) && (a == '0)) begin
            v = '0;
        end
        return v;
    endfunction

    function automatic logic read_busy(input logic [ADDR_W-1:0] a);
        logic b;
        b = busy[a];
        if ((BYPASS != 0) && wb_en && (wb_addr == a)) begin
            b = 1'b0;
        end
        if ((ZERO_REG != 0) && (a == '0)) begin
            b = 1'b0;
        end
        return b;
    endfunction

    always_comb begin
        rd_data1 = read_data(rd_addr1);
        rd_data2 = read_data(rd_addr2);
        rd_busy1 = read_busy(rd_addr1);
        rd_busy2 = read_busy(rd_addr2);
    end

    assign busy_vec = busy;

endmodule
